// File: rtl/rf_arb_pkg.sv
//-----------------------------------------------------------------------------
// rf_arb_pkg
// Shared types and constants for the register-file arbiter.
//   state_t   : arbiter FSM states (IDLE accepts requests, RD_WAIT waits for
//               the register file read return)
//   owner_t   : which requester owns the outstanding read
//   ALU_OPERAND_LIMIT : addresses below this hold live ALU operands
//   cnt_width : width of the read-timeout counter for a given timeout
//-----------------------------------------------------------------------------
package rf_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   typedef enum logic {
      OWN_SYS = 1'b0,   // requester 0, system controller
      OWN_DBG = 1'b1    // requester 1, config/debug port
   } owner_t;

   localparam int unsigned ALU_OPERAND_LIMIT = 2;

   // Counter must be able to hold RD_TIMEOUT-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout < 2) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage : rf_arb_pkg

// File: rtl/rf_arb_rr.sv
//-----------------------------------------------------------------------------
// rf_arb_rr
// Two-way round-robin picker. Purely combinational.
//   eligible[1:0] in  : requester i may be granted this cycle
//   last          in  : index of the requester granted most recently
//   grant[1:0]    out : one-hot winner, all zero when nobody is eligible
// On a tie the requester that was NOT granted last wins.
//-----------------------------------------------------------------------------
module rf_arb_rr (
   input  logic [1:0] eligible,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven,
      // so no latch is inferred when no branch matches.
      grant = 2'b00;
      case (eligible)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule : rf_arb_rr

// File: rtl/rf_arbiter.sv
//-----------------------------------------------------------------------------
// rf_arbiter
// Arbitrates two requesters onto a single-ported register file.
//
// Ports
//   CLK, RST                 : clock, asynchronous active-low reset
//   REQ0/1, WR0/1            : request, 1 = write / 0 = read
//   ADDR0/1, WDATA0/1        : request address and write data
//   GNT0/1                   : one-cycle pulse, request accepted this cycle
//   RDATA0/1                 : registered read data per requester
//   RDATA_VLD0/1             : one-cycle pulse, RDATA just updated
//   RD_ERR0/1                : one-cycle pulse, read timed out
//   ALU_LOCK                 : ALU operand registers (addr 0,1) in use
//   Addr, Wr_Reg, WrEn, RdEn : register file strobes (combinational)
//   Rd_Reg, Rd_Reg_Valid     : register file read return
//
// Grants are combinational in IDLE. A write finishes in its grant cycle; a
// read parks the FSM in RD_WAIT until the register file answers or the
// timeout counter expires. Read results are registered, so RDATA_VLD/RD_ERR
// appear the cycle after the event that caused them.
//-----------------------------------------------------------------------------
module rf_arbiter
   import rf_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RD_TIMEOUT = 8
) (
   input  logic                  CLK,
   input  logic                  RST,

   input  logic                  REQ0,
   input  logic                  REQ1,
   input  logic                  WR0,
   input  logic                  WR1,
   input  logic [ADDR_WIDTH-1:0] ADDR0,
   input  logic [ADDR_WIDTH-1:0] ADDR1,
   input  logic [DATA_WIDTH-1:0] WDATA0,
   input  logic [DATA_WIDTH-1:0] WDATA1,

   output logic                  GNT0,
   output logic                  GNT1,
   output logic [DATA_WIDTH-1:0] RDATA0,
   output logic [DATA_WIDTH-1:0] RDATA1,
   output logic                  RDATA_VLD0,
   output logic                  RDATA_VLD1,
   output logic                  RD_ERR0,
   output logic                  RD_ERR1,

   input  logic                  ALU_LOCK,

   output logic [ADDR_WIDTH-1:0] Addr,
   output logic [DATA_WIDTH-1:0] Wr_Reg,
   output logic                  WrEn,
   output logic                  RdEn,
   input  logic [DATA_WIDTH-1:0] Rd_Reg,
   input  logic                  Rd_Reg_Valid
);

   localparam int unsigned           CNT_W    = cnt_width(RD_TIMEOUT);
   // Value the counter holds during the last allowed wait cycle.
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] ALU_LIM  = ADDR_WIDTH'(ALU_OPERAND_LIMIT);

   //--------------------------------------------------------------------------
   // State
   //--------------------------------------------------------------------------
   state_t                       state_q, state_d;
   owner_t                       owner_q, owner_d;
   logic                         last_q,  last_d;
   logic [CNT_W-1:0]             cnt_q,   cnt_d;
   logic [1:0][DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]                   vld_q,   vld_d;
   logic [1:0]                   err_q,   err_d;

   //--------------------------------------------------------------------------
   // Eligibility and arbitration
   //--------------------------------------------------------------------------
   logic                  arb_en;
   logic                  alu_block;
   logic [1:0]            eligible;
   logic [1:0]            gnt;
   logic                  win_idx;
   logic                  win_wr;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;
   logic                  own_idx;

   // Grants only from IDLE, and never while reset is held so that every
   // strobe stays low during reset even with requests pending.
   assign arb_en    = (state_q == IDLE) && RST;

   // The debug port may not overwrite an ALU operand while the ALU holds it;
   // reads and writes elsewhere are unaffected.
   assign alu_block = ALU_LOCK && WR1 && (ADDR1 < ALU_LIM);

   assign eligible  = arb_en ? {REQ1 && !alu_block, REQ0} : 2'b00;

   rf_arb_rr u_rr (
      .eligible (eligible),
      .last     (last_q),
      .grant    (gnt)
   );

   // gnt is one-hot, so bit 1 alone identifies the winner.
   assign win_idx   = gnt[1];
   assign win_wr    = win_idx ? WR1    : WR0;
   assign win_addr  = win_idx ? ADDR1  : ADDR0;
   assign win_wdata = win_idx ? WDATA1 : WDATA0;
   assign own_idx   = (owner_q == OWN_DBG);

   assign GNT0 = gnt[0];
   assign GNT1 = gnt[1];

   //--------------------------------------------------------------------------
   // Next-state and strobe logic
   //--------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      vld_d   = '0;
      err_d   = '0;
      Addr    = '0;
      Wr_Reg  = '0;
      WrEn    = 1'b0;
      RdEn    = 1'b0;

      case (state_q)
         IDLE: begin
            // Rd_Reg_Valid is deliberately not looked at here.
            if (|gnt) begin
               Addr   = win_addr;
               Wr_Reg = win_wdata;
               WrEn   = win_wr;
               RdEn   = !win_wr;
               last_d = win_idx;
               if (!win_wr) begin
                  owner_d = win_idx ? OWN_DBG : OWN_SYS;
                  cnt_d   = '0;
                  state_d = RD_WAIT;
               end
            end
         end

         RD_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A return in the timeout cycle still wins over the timeout.
            if (Rd_Reg_Valid) begin
               rdata_d[own_idx] = Rd_Reg;
               vld_d[own_idx]   = 1'b1;
               state_d          = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_d[own_idx] = 1'b1;
               state_d        = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   //--------------------------------------------------------------------------
   // Registers
   //--------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         owner_q <= OWN_SYS;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         // NOTE: the read-data holding registers are reset too, because
         // RDATA is a visible output that must read zero after reset.
         rdata_q <= '0;
         vld_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   assign RDATA0     = rdata_q[0];
   assign RDATA1     = rdata_q[1];
   assign RDATA_VLD0 = vld_q[0];
   assign RDATA_VLD1 = vld_q[1];
   assign RD_ERR0    = err_q[0];
   assign RD_ERR1    = err_q[1];

endmodule : rf_arbiter

// File: tb/tb_rf_arbiter.sv
//-----------------------------------------------------------------------------
// tb_rf_arbiter
// Self-checking bench for rf_arbiter. Single-cycle grant behaviour is
// table-driven; reads use a scoreboard queue of expected responses that a
// monitor pops whenever RDATA_VLD or RD_ERR pulses.
//-----------------------------------------------------------------------------
module tb_rf_arbiter;

   logic       CLK;
   logic       RST;
   logic       REQ0, REQ1, WR0, WR1;
   logic [3:0] ADDR0, ADDR1;
   logic [7:0] WDATA0, WDATA1;
   logic       GNT0, GNT1;
   logic [7:0] RDATA0, RDATA1;
   logic       RDATA_VLD0, RDATA_VLD1, RD_ERR0, RD_ERR1;
   logic       ALU_LOCK;
   logic [3:0] Addr;
   logic [7:0] Wr_Reg;
   logic       WrEn, RdEn;
   logic [7:0] Rd_Reg;
   logic       Rd_Reg_Valid;

   rf_arbiter #(
      .ADDR_WIDTH (4),
      .DATA_WIDTH (8),
      .RD_TIMEOUT (8)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .REQ0         (REQ0),
      .REQ1         (REQ1),
      .WR0          (WR0),
      .WR1          (WR1),
      .ADDR0        (ADDR0),
      .ADDR1        (ADDR1),
      .WDATA0       (WDATA0),
      .WDATA1       (WDATA1),
      .GNT0         (GNT0),
      .GNT1         (GNT1),
      .RDATA0       (RDATA0),
      .RDATA1       (RDATA1),
      .RDATA_VLD0   (RDATA_VLD0),
      .RDATA_VLD1   (RDATA_VLD1),
      .RD_ERR0      (RD_ERR0),
      .RD_ERR1      (RD_ERR1),
      .ALU_LOCK     (ALU_LOCK),
      .Addr         (Addr),
      .Wr_Reg       (Wr_Reg),
      .WrEn         (WrEn),
      .RdEn         (RdEn),
      .Rd_Reg       (Rd_Reg),
      .Rd_Reg_Valid (Rd_Reg_Valid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       who;
      logic       is_err;
      logic [7:0] data;
   } rd_exp_t;

   rd_exp_t    sb_q[$];
   logic [7:0] mrd [2];   // model of RDATA0/RDATA1

   typedef struct {
      logic       req0, req1, wr0, wr1, lock;
      logic [3:0] a0, a1;
      logic [7:0] d0, d1;
      logic       g0, g1, we, re;
      logic [3:0] addr;
      logic [7:0] wd;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   task automatic idle_inputs();
      REQ0 = 1'b0; REQ1 = 1'b0; WR0 = 1'b0; WR1 = 1'b0;
      ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
      ALU_LOCK = 1'b0; Rd_Reg = '0; Rd_Reg_Valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt0"},   32'(GNT0),       32'd0);
      check({tag, "_gnt1"},   32'(GNT1),       32'd0);
      check({tag, "_wren"},   32'(WrEn),       32'd0);
      check({tag, "_rden"},   32'(RdEn),       32'd0);
      check({tag, "_addr"},   32'(Addr),       32'd0);
      check({tag, "_wrreg"},  32'(Wr_Reg),     32'd0);
      check({tag, "_rdata0"}, 32'(RDATA0),     32'd0);
      check({tag, "_rdata1"}, 32'(RDATA1),     32'd0);
      check({tag, "_vld0"},   32'(RDATA_VLD0), 32'd0);
      check({tag, "_vld1"},   32'(RDATA_VLD1), 32'd0);
      check({tag, "_err0"},   32'(RD_ERR0),    32'd0);
      check({tag, "_err1"},   32'(RD_ERR1),    32'd0);
   endtask

   // Reset with a write request pending: strobes must still stay low.
   task automatic do_reset();
      RST = 1'b0;
      sb_q.delete();
      mrd[0] = '0;
      mrd[1] = '0;
      idle_inputs();
      REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 4'd5; WDATA0 = 8'h3C;
      sample();
      check_reset_outputs("rst");
      idle_inputs();
      next_cycle();
      RST = 1'b1;
   endtask

   //--------------------------------------------------------------------------
   // Read-response monitor / scoreboard
   //--------------------------------------------------------------------------
   always @(negedge CLK) begin : monitor
      logic    v, e;
      rd_exp_t x;
      if (RST) begin
         for (int r = 0; r < 2; r++) begin
            v = (r == 0) ? RDATA_VLD0 : RDATA_VLD1;
            e = (r == 0) ? RD_ERR0    : RD_ERR1;
            if (v || e) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected: requester %0d vld=%0b err=%0b, expected no response",
                           r, v, e);
               end else begin
                  x = sb_q.pop_front();
                  check("sb_owner", 32'(r), 32'(x.who));
                  check("sb_err",   32'(e), 32'(x.is_err));
                  check("sb_vld",   32'(v), 32'(!x.is_err));
                  if (!x.is_err) mrd[x.who] = x.data;
               end
            end
         end
         // Holding registers: owner gets new data only on success, the
         // other requester's RDATA never moves.
         check("sb_rdata0", 32'(RDATA0), 32'(mrd[0]));
         check("sb_rdata1", 32'(RDATA1), 32'(mrd[1]));
      end
   end

   //--------------------------------------------------------------------------
   // Stimulus
   //--------------------------------------------------------------------------
   initial begin
      //          req0 req1 wr0 wr1 lk  a0     a1     d0     d1      g0 g1 we re addr   wd
      // LAST_GNT starts at 1 after reset; comments show it after each row.
      vecs[0]  = '{1, 0, 1, 0, 0, 4'd5,  4'd0, 8'h3C, 8'h00,   1, 0, 1, 0, 4'd5,  8'h3C}; // last 0
      vecs[1]  = '{0, 0, 1, 1, 0, 4'd9,  4'd6, 8'hAA, 8'hBB,   0, 0, 0, 0, 4'd0,  8'h00}; // last 0
      vecs[2]  = '{1, 1, 1, 1, 0, 4'd2,  4'd7, 8'h10, 8'h20,   0, 1, 1, 0, 4'd7,  8'h20}; // last 1
      vecs[3]  = '{1, 1, 1, 1, 0, 4'd2,  4'd7, 8'h10, 8'h20,   1, 0, 1, 0, 4'd2,  8'h10}; // last 0
      vecs[4]  = '{1, 1, 1, 1, 0, 4'd2,  4'd7, 8'h10, 8'h20,   0, 1, 1, 0, 4'd7,  8'h20}; // last 1
      vecs[5]  = '{1, 1, 1, 1, 1, 4'd3,  4'd1, 8'h33, 8'h44,   1, 0, 1, 0, 4'd3,  8'h33}; // last 0
      vecs[6]  = '{0, 1, 0, 1, 1, 4'd0,  4'd1, 8'h00, 8'h44,   0, 0, 0, 0, 4'd0,  8'h00}; // last 0
      vecs[7]  = '{0, 1, 0, 1, 1, 4'd0,  4'd2, 8'h00, 8'h46,   0, 1, 1, 0, 4'd2,  8'h46}; // last 1
      vecs[8]  = '{0, 1, 0, 1, 1, 4'd0,  4'd0, 8'h00, 8'h47,   0, 0, 0, 0, 4'd0,  8'h00}; // last 1
      vecs[9]  = '{1, 1, 1, 1, 1, 4'd4,  4'd0, 8'h48, 8'h49,   1, 0, 1, 0, 4'd4,  8'h48}; // last 0
      vecs[10] = '{0, 1, 0, 1, 0, 4'd0,  4'd0, 8'h00, 8'h55,   0, 1, 1, 0, 4'd0,  8'h55}; // last 1
      vecs[11] = '{1, 0, 1, 0, 1, 4'd1,  4'd0, 8'h66, 8'h00,   1, 0, 1, 0, 4'd1,  8'h66}; // last 0

      RST = 1'b0;
      idle_inputs();
      mrd[0] = '0;
      mrd[1] = '0;
      next_cycle();

      // ---- Simultaneous reads straight out of reset -----------------------
      do_reset();
      REQ0 = 1'b1; WR0 = 1'b0; ADDR0 = 4'd3;
      REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 4'd4;
      sample();                                   // cycle N
      check("rd2_gnt0_n",  32'(GNT0), 32'd1);
      check("rd2_gnt1_n",  32'(GNT1), 32'd0);
      check("rd2_rden_n",  32'(RdEn), 32'd1);
      check("rd2_wren_n",  32'(WrEn), 32'd0);
      check("rd2_addr_n",  32'(Addr), 32'd3);
      sb_q.push_back('{1'b0, 1'b0, 8'h11});
      next_cycle();                               // N+1: RD_WAIT
      REQ0 = 1'b0;
      Rd_Reg = 8'h11; Rd_Reg_Valid = 1'b1;
      sample();
      check("rd2_gnt1_wait", 32'(GNT1), 32'd0);
      check("rd2_rden_wait", 32'(RdEn), 32'd0);
      next_cycle();                               // N+2
      Rd_Reg_Valid = 1'b0; Rd_Reg = 8'h00;
      sample();
      check("rd2_vld0_n2", 32'(RDATA_VLD0), 32'd1);
      check("rd2_data0",   32'(RDATA0),     32'h11);
      check("rd2_gnt1_n2", 32'(GNT1),       32'd1);
      check("rd2_addr_n2", 32'(Addr),       32'd4);
      sb_q.push_back('{1'b1, 1'b0, 8'h22});
      next_cycle();                               // N+3
      REQ1 = 1'b0;
      Rd_Reg = 8'h22; Rd_Reg_Valid = 1'b1;
      sample();
      check("rd2_vld0_n3", 32'(RDATA_VLD0), 32'd0);
      next_cycle();                               // N+4
      Rd_Reg_Valid = 1'b0; Rd_Reg = 8'h00;
      sample();
      check("rd2_vld1_n4", 32'(RDATA_VLD1), 32'd1);
      check("rd2_data1",   32'(RDATA1),     32'h22);
      check("rd2_data0_kept", 32'(RDATA0),  32'h11);
      next_cycle();

      // ---- Rd_Reg_Valid while IDLE is ignored -------------------------------
      Rd_Reg = 8'h77; Rd_Reg_Valid = 1'b1;
      next_cycle();
      Rd_Reg_Valid = 1'b0;
      sample();
      check("idle_vld0", 32'(RDATA_VLD0), 32'd0);
      check("idle_vld1", 32'(RDATA_VLD1), 32'd0);
      check("idle_data1", 32'(RDATA1),    32'h22);
      next_cycle();

      // ---- Table-driven single-cycle grants ---------------------------------
      do_reset();
      foreach (vecs[i]) begin
         REQ0 = vecs[i].req0; REQ1 = vecs[i].req1;
         WR0 = vecs[i].wr0;   WR1 = vecs[i].wr1;
         ADDR0 = vecs[i].a0;  ADDR1 = vecs[i].a1;
         WDATA0 = vecs[i].d0; WDATA1 = vecs[i].d1;
         ALU_LOCK = vecs[i].lock;
         sample();
         check($sformatf("vec%0d_gnt0", i),  32'(GNT0),   32'(vecs[i].g0));
         check($sformatf("vec%0d_gnt1", i),  32'(GNT1),   32'(vecs[i].g1));
         check($sformatf("vec%0d_wren", i),  32'(WrEn),   32'(vecs[i].we));
         check($sformatf("vec%0d_rden", i),  32'(RdEn),   32'(vecs[i].re));
         check($sformatf("vec%0d_addr", i),  32'(Addr),   32'(vecs[i].addr));
         check($sformatf("vec%0d_wrreg", i), 32'(Wr_Reg), 32'(vecs[i].wd));
         next_cycle();
      end
      idle_inputs();

      // ---- ALU lock holds off a debug write to an operand address ----------
      ALU_LOCK = 1'b1;
      REQ1 = 1'b1; WR1 = 1'b1; ADDR1 = 4'd1; WDATA1 = 8'h77;
      for (int k = 0; k < 3; k++) begin
         sample();
         check($sformatf("lock_gnt1_%0d", k), 32'(GNT1), 32'd0);
         check($sformatf("lock_wren_%0d", k), 32'(WrEn), 32'd0);
         next_cycle();
      end
      ALU_LOCK = 1'b0;
      sample();
      check("unlock_gnt1",  32'(GNT1),   32'd1);
      check("unlock_addr",  32'(Addr),   32'd1);
      check("unlock_wrreg", 32'(Wr_Reg), 32'h77);
      check("unlock_wren",  32'(WrEn),   32'd1);
      next_cycle();
      idle_inputs();

      // ---- Read return exactly in the timeout cycle -------------------------
      REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 4'd6;
      sample();                                   // cycle N
      check("tocyc_gnt1", 32'(GNT1), 32'd1);
      sb_q.push_back('{1'b1, 1'b0, 8'hA5});
      next_cycle();
      REQ1 = 1'b0;
      for (int k = 1; k <= 7; k++) begin          // N+1 .. N+7
         sample();
         check($sformatf("tocyc_vld1_%0d", k), 32'(RDATA_VLD1), 32'd0);
         check($sformatf("tocyc_err1_%0d", k), 32'(RD_ERR1),    32'd0);
         next_cycle();
      end
      Rd_Reg = 8'hA5; Rd_Reg_Valid = 1'b1;        // N+8, the timeout cycle
      sample();
      check("tocyc_err1_8", 32'(RD_ERR1), 32'd0);
      next_cycle();                               // N+9
      Rd_Reg_Valid = 1'b0; Rd_Reg = 8'h00;
      sample();
      check("tocyc_vld1", 32'(RDATA_VLD1), 32'd1);
      check("tocyc_err1", 32'(RD_ERR1),    32'd0);
      check("tocyc_data", 32'(RDATA1),     32'hA5);
      check("tocyc_vld0", 32'(RDATA_VLD0), 32'd0);
      next_cycle();

      // ---- Read timeout with a write queued behind it ----------------------
      REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 4'd6;
      sample();                                   // cycle N
      check("to_gnt1", 32'(GNT1), 32'd1);
      sb_q.push_back('{1'b1, 1'b1, 8'h00});
      next_cycle();
      REQ1 = 1'b0;
      REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 4'd8; WDATA0 = 8'h88;
      for (int k = 1; k <= 8; k++) begin          // N+1 .. N+8 in RD_WAIT
         sample();
         check($sformatf("to_gnt0_%0d", k), 32'(GNT0),    32'd0);
         check($sformatf("to_err1_%0d", k), 32'(RD_ERR1), 32'd0);
         next_cycle();
      end
      sample();                                   // N+9
      check("to_err1",  32'(RD_ERR1),    32'd1);
      check("to_vld1",  32'(RDATA_VLD1), 32'd0);
      check("to_data1", 32'(RDATA1),     32'hA5);
      check("to_gnt0",  32'(GNT0),       32'd1);
      check("to_wren",  32'(WrEn),       32'd1);
      check("to_addr",  32'(Addr),       32'd8);
      next_cycle();
      idle_inputs();
      sample();
      check("to_err1_after", 32'(RD_ERR1), 32'd0);
      next_cycle();

      // ---- Reset during RD_WAIT abandons the read ---------------------------
      REQ0 = 1'b1; WR0 = 1'b0; ADDR0 = 4'd2;
      sample();
      check("rstw_gnt0", 32'(GNT0), 32'd1);
      next_cycle();                               // now in RD_WAIT
      REQ0 = 1'b0;
      #2;
      RST = 1'b0;
      sb_q.delete();
      mrd[0] = '0;
      mrd[1] = '0;
      Rd_Reg = 8'h5A; Rd_Reg_Valid = 1'b1;
      sample();
      check_reset_outputs("rstw");
      next_cycle();
      RST = 1'b1;                                 // return still asserted
      sample();
      check("rstw_vld0_a", 32'(RDATA_VLD0), 32'd0);
      next_cycle();
      Rd_Reg_Valid = 1'b0; Rd_Reg = 8'h00;
      sample();
      check("rstw_vld0_b",  32'(RDATA_VLD0), 32'd0);
      check("rstw_err0_b",  32'(RD_ERR0),    32'd0);
      check("rstw_rdata0",  32'(RDATA0),     32'd0);
      next_cycle();

      // ---- Drain the scoreboard with a bounded wait -------------------------
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) next_cycle();
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rf_arbiter
